decipher_stream: RTL and testbench

- Iterative AES inverse cipher for AES-128, AES-192 and AES-256 (Nr = 10/12/14); one 128-bit block in flight.
- Generalised successor of the single-mode decipher core:
  - parametrised round-key memory latency;
  - valid/ready input and output with backpressure;
  - explicit error reporting;
  - optional pipelined key prefetch.
- Sits between the AXI-stream command FSM and the round-key BRAM. Requests round keys by index and consumes them on key_valid.

---
 rtl/aes_pkg.sv | 104 ++++++++++
 rtl/inv_round.sv | 26 ++
 rtl/decipher_stream.sv | 171 +++++++++++++++++
 tb/tb_decipher_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES inverse-cipher constants, types and byte-level transforms shared by the decipher slice.
// Latency: none, pure functions and type definitions.
// Backpressure: not applicable.
package aes_pkg;

  localparam logic [3:0] NR_128     = 4'd10;
  localparam logic [3:0] NR_192     = 4'd12;
  localparam logic [3:0] NR_256     = 4'd14;
  localparam int         AES_NR_MAX = 14;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } dec_state_t;

  typedef enum logic [1:0] {
    STEP_FIRST,
    STEP_MID,
    STEP_LAST
  } step_kind_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Only the three AES key sizes define a usable round count.
  function automatic logic nr_legal(input logic [3:0] n);
    return (n == NR_128) || (n == NR_192) || (n == NR_256);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (enough for 9/11/13/14).
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  // Byte 0 sits in bits [127:120]; bytes fill the state column by column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
      o[119-32*c -: 8] = gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13);
      o[111-32*c -: 8] = gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11);
      o[103-32*c -: 8] = gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_round.sv
// One inverse-cipher step: initial key add, full middle round, or final round without InvMixColumns.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  step_kind_t   kind,
  output logic [127:0] result
);

  logic [127:0] sub_add;

  // Select the step shape; middle rounds mix columns after the key add.
  always_comb begin
    sub_add = inv_sub_bytes(inv_shift_rows(state)) ^ key;
    result  = sub_add;
    case (kind)
      STEP_FIRST: result = state ^ key;
      STEP_MID:   result = inv_mix_columns(sub_add);
      default:    result = sub_add;
    endcase
  end

endmodule

// File: rtl/decipher_stream.sv
// Iterative AES-128/192/256 inverse cipher fetching round keys Nr..0 from an external key memory.
// Latency: (Nr+1)*(KEY_LAT+1) cycles; with DECIPHER_KEY_PREFETCH_EN, Nr+1+KEY_LAT cycles.
// Backpressure: plaintext held with out_valid until out_ready; in_ready low from acceptance to handshake.
module decipher_stream
  import aes_pkg::*;
#(
  parameter int KEY_LAT = 2,
  parameter int NR_MAX  = AES_NR_MAX,
  parameter int BLK_S   = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_S-1:0] ciphertext,
  input  logic [3:0]       rounds_total,
  output logic             key_req,
  output logic [3:0]       round_key_no,
  input  logic [BLK_S-1:0] key,
  input  logic             key_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_S-1:0] plaintext,
  output logic             out_err
);

  localparam int DW = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;

  dec_state_t       state;
  logic [DW-1:0]    drain_cnt;
  logic [3:0]       r;
  logic [3:0]       nr_q;
  logic [BLK_S-1:0] blk;
  logic [BLK_S-1:0] step_out;
  step_kind_t       kind;
  logic             nr_ok;

`ifdef DECIPHER_KEY_PREFETCH_EN
  localparam int OW = $clog2(KEY_LAT + 2);
  logic [OW-1:0] outst;
  logic          got;

  // A reply is only meaningful when a request is still in flight.
  always_comb begin
    got = key_valid && (outst != '0);
  end
`endif

  // Step shape follows the round counter relative to the latched Nr.
  always_comb begin
    nr_ok = nr_legal(rounds_total) && (int'(rounds_total) <= NR_MAX);
    kind  = STEP_MID;
    if (r == nr_q)     kind = STEP_FIRST;
    else if (r == 4'd0) kind = STEP_LAST;
  end

  inv_round u_round (
    .state  (blk),
    .key    (key),
    .kind   (kind),
    .result (step_out)
  );

  // Control FSM with registered handshake, key-request and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_DRAIN;
      drain_cnt    <= '0;
      in_ready     <= 1'b0;
      key_req      <= 1'b0;
      round_key_no <= 4'd0;
      out_valid    <= 1'b0;
      out_err      <= 1'b0;
      plaintext    <= '0;
      blk          <= '0;
      r            <= 4'd0;
      nr_q         <= 4'd0;
`ifdef DECIPHER_KEY_PREFETCH_EN
      outst        <= '0;
`endif
    end else begin
      case (state)
        // Let replies to requests issued before reset drain away unseen.
        ST_DRAIN: begin
          if (drain_cnt == DW'(KEY_LAT - 1)) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            blk      <= ciphertext;
            nr_q     <= rounds_total;
            r        <= rounds_total;
            if (nr_ok) begin
              state        <= ST_REQ;
              key_req      <= 1'b1;
              round_key_no <= rounds_total;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              plaintext <= '0;
            end
          end
        end
`ifdef DECIPHER_KEY_PREFETCH_EN
        ST_REQ, ST_WAIT: begin
          if (state == ST_REQ) begin
            if (round_key_no == 4'd0) begin
              key_req <= 1'b0;
              state   <= ST_WAIT;
            end else begin
              round_key_no <= round_key_no - 4'd1;
            end
          end
          outst <= outst + OW'(key_req) - OW'(got);
          if (got) begin
            blk <= step_out;
            if (r == 4'd0) begin
              plaintext <= step_out;
              out_valid <= 1'b1;
              key_req   <= 1'b0;
              state     <= ST_DONE;
            end else begin
              r <= r - 4'd1;
            end
          end
        end
`else
        ST_REQ: begin
          key_req <= 1'b0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (key_valid) begin
            blk <= step_out;
            if (r == 4'd0) begin
              plaintext <= step_out;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              r            <= r - 4'd1;
              round_key_no <= r - 4'd1;
              key_req      <= 1'b1;
              state        <= ST_REQ;
            end
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_DRAIN;
          drain_cnt <= '0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decipher_stream.sv
// Self-checking bench for decipher_stream: FIPS-197 vectors, backpressure, illegal Nr, mid-round reset.
// Latency: checked against the closed-form cycle count for the active build.
// Backpressure: exercised by holding out_ready low while a new block is offered.
module tb_decipher_stream;

  localparam int KEY_LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rounds_total;
  logic         key_req;
  logic [3:0]   round_key_no;
  logic [127:0] key;
  logic         key_valid;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         out_err;

  typedef struct {
    logic [127:0] ct;
    logic [3:0]   nr;
    logic [255:0] k;
    logic [127:0] pt;
    logic         err;
    int           hold;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    logic         err;
  } exp_t;

  typedef struct {
    int         c;
    logic [3:0] idx;
  } req_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  exp_t         sb_q[$];
  req_t         req_hist[$];
  logic [7:0]   fsbox[256];
  logic [127:0] cur_rk[16];
  logic [KEY_LAT-1:0]      pipe_v = '0;
  logic [KEY_LAT-1:0][3:0] pipe_idx = '0;
  vec_t         vt[8];

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  decipher_stream #(.KEY_LAT(KEY_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ciphertext   (ciphertext),
    .rounds_total (rounds_total),
    .key_req      (key_req),
    .round_key_no (round_key_no),
    .key          (key),
    .key_valid    (key_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .plaintext    (plaintext),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key memory: answers each request KEY_LAT cycles later; not cleared by reset.
  always @(posedge clk) begin
    pipe_v[0]   <= key_req;
    pipe_idx[0] <= round_key_no;
    for (int i = 1; i < KEY_LAT; i++) begin
      pipe_v[i]   <= pipe_v[i-1];
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end
  assign key_valid = pipe_v[KEY_LAT-1];
  assign key       = cur_rk[pipe_idx[KEY_LAT-1]];

  // Request log for order / burst-length checks.
  always @(posedge clk) begin
    if (key_req) req_hist.push_back('{cyc, round_key_no});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {fsbox[w[31:24]], fsbox[w[23:16]], fsbox[w[15:8]], fsbox[w[7:0]]};
  endfunction

  // Forward S-box from GF inverse plus affine map, independent of the design's table.
  task automatic build_sbox();
    logic [7:0] p, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      p = 8'h01;
      for (int j = 0; j < 254; j++) p = gmul(p, xb);
      fsbox[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [255:0] k, input int nr);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) cur_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_block(input vec_t v);
    int n, acc, start, cnt, exp_cnt, exp_lat, exp_run, cur, mr, prevc;
    bit ok;
    exp_t e;
`ifdef DECIPHER_KEY_PREFETCH_EN
    exp_lat = int'(v.nr) + 1 + KEY_LAT;
    exp_run = int'(v.nr) + 1;
`else
    exp_lat = (int'(v.nr) + 1) * (KEY_LAT + 1);
    exp_run = 1;
`endif
    if (!v.err) expand(v.k, int'(v.nr));
    start = req_hist.size();
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("in_ready_timeout", 128'(in_ready), 128'(1)); return; end
    in_valid = 1'b1; ciphertext = v.ct; rounds_total = v.nr;
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0; ciphertext = ~v.ct; rounds_total = 4'd3;
    sb_q.push_back('{v.pt, v.err});
    n = 0;
    while (!out_valid && n < 2000) begin @(negedge clk); n++; end
    if (!out_valid) begin
      chk("out_valid_timeout", 128'(out_valid), 128'(1));
      void'(sb_q.pop_front());
      return;
    end
    if (!v.err) chk("latency", 128'(cyc - acc), 128'(exp_lat));
    if (v.hold > 0) begin
      in_valid = 1'b1; ciphertext = CT256; rounds_total = 4'd14;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_plaintext", plaintext, v.pt);
      end
      in_valid = 1'b0;
    end
    e = sb_q.pop_front();
    chk("plaintext", plaintext, e.pt);
    chk("out_err", 128'(out_err), 128'(e.err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 128'(out_valid), 128'(0));
    chk("in_ready_reopen", 128'(in_ready), 128'(1));
    cnt = req_hist.size() - start;
    exp_cnt = v.err ? 0 : int'(v.nr) + 1;
    chk("key_req_count", 128'(cnt), 128'(exp_cnt));
    if (!v.err && cnt == exp_cnt) begin
      ok = 1'b1; mr = 0; cur = 0; prevc = -10;
      for (int k = 0; k < cnt; k++) begin
        if (req_hist[start+k].idx != 4'(int'(v.nr) - k)) ok = 1'b0;
        cur = (req_hist[start+k].c == prevc + 1) ? cur + 1 : 1;
        if (cur > mr) mr = cur;
        prevc = req_hist[start+k].c;
      end
      chk("key_req_order", 128'(ok), 128'(1));
      chk("key_req_burst", 128'(mr), 128'(exp_run));
    end
  endtask

  // Abort a block at round 5 with a reply still in flight.
  task automatic reset_mid();
    int n;
    expand(K128, 10);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b1; ciphertext = CT128; rounds_total = 4'd10;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(key_req && round_key_no == 4'd5) && n < 500) begin @(negedge clk); n++; end
    chk("reach_round5", 128'(key_req && round_key_no == 4'd5), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < KEY_LAT; i++) begin
      chk("drain_in_ready", 128'(in_ready), 128'(0));
      chk("drain_out_valid", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    chk("drain_done_in_ready", 128'(in_ready), 128'(1));
    chk("drain_no_output", 128'(out_valid), 128'(0));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ciphertext = '0; rounds_total = 4'd0;
    for (int i = 0; i < 16; i++) cur_rk[i] = '0;
    build_sbox();
    vt[0] = '{CT128, 4'd10, K128, PT,   1'b0, 0};
    vt[1] = '{CT192, 4'd12, K192, PT,   1'b0, 0};
    vt[2] = '{CT256, 4'd14, K256, PT,   1'b0, 0};
    vt[3] = '{CT128, 4'd10, K128, PT,   1'b0, 20};
    vt[4] = '{CT128, 4'd11, K128, '0,   1'b1, 0};
    vt[5] = '{CT192, 4'd12, K192, PT,   1'b0, 0};
    vt[6] = '{CT256, 4'd15, K256, '0,   1'b1, 0};
    vt[7] = '{CT256, 4'd14, K256, PT,   1'b0, 0};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_key_req", 128'(key_req), 128'(0));
    chk("rst_round_key_no", 128'(round_key_no), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_err", 128'(out_err), 128'(0));
    chk("rst_plaintext", plaintext, 128'(0));
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_block(vt[i]);
    reset_mid();
    run_block(vt[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
